// File: rtl/seg_digit_scanner.sv
// Four-digit multiplexed display scanner with a host-written shadow register that is
// copied to the displayed register only at a frame boundary, plus leading-zero blanking.
module seg_digit_scanner #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic       lz_blank,
    output logic       commit_pend,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic [3:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]  count;
    logic [1:0]        idx;
    logic [3:0][3:0]   shadow;
    logic [3:0][3:0]   active;

    logic              tick;
    logic              frame_boundary;
    logic              do_copy;
    logic [1:0]        idx_p0;
    logic [3:0][3:0]   active_p0;
    logic [3:0]        code_p0;
    logic [3:0]        an_p0;
    logic [3:0]        code_p1;
    logic [3:0]        an_p1;

    // Slot k is dark when blanking is on, k is not the rightmost digit, and every
    // digit from k up to the leftmost is zero.
    function automatic logic slot_blanked(input logic [1:0] k,
                                          input logic [3:0][3:0] act,
                                          input logic lz);
        logic nonzero;
        nonzero = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(k) && act[j] != 4'd0)
                nonzero = 1'b1;
        end
        return lz && (k != 2'd0) && !nonzero;
    endfunction

    assign tick           = (count == CNT_MAX);
    assign frame_boundary = tick && (idx == 2'd3);
    assign do_copy        = frame_boundary && (commit_pend || commit);

    // Stage p0: next slot/active values, so registered outputs track them with no extra lag
    always_comb begin
        idx_p0    = tick ? idx + 2'd1 : idx;
        active_p0 = do_copy ? shadow : active;
        code_p0   = active_p0[idx_p0];
        an_p0     = slot_blanked(idx_p0, active_p0, lz_blank) ? 4'b0000
                                                              : (4'b0001 << idx_p0);
    end

    // Stage p1: state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            idx         <= 2'd0;
            shadow      <= '0;
            active      <= '0;
            commit_pend <= 1'b0;
            code_p1     <= 4'd0;
            an_p1       <= 4'b0001;
        end else begin
            count       <= tick ? '0 : count + 1'b1;
            idx         <= idx_p0;
            active      <= active_p0;
            if (frame_boundary)
                commit_pend <= 1'b0;
            else if (commit)
                commit_pend <= 1'b1;
            if (wr_en)
                shadow[wr_addr] <= wr_data;
            code_p1     <= code_p0;
            an_p1       <= an_p0;
        end
    end

    assign {x0, x1, x2, x3} = code_p1;
    assign an               = an_p1;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Self-checking bench for seg_digit_scanner (SCAN_DIV=4): directed scenarios plus random
// traffic, compared every cycle against a cycle-count based reference model.
module tb_seg_digit_scanner;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst, wr_en, commit, lz_blank;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit_pend;
    logic       x0, x1, x2, x3;
    logic [3:0] an;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time since reset decides slot and frame position directly.
    int       t;
    int       m_sh [4];
    int       m_act[4];
    bit       m_pend;

    seg_digit_scanner #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .lz_blank(lz_blank), .commit_pend(commit_pend),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int cur_slot();
        return (t / DIV) % 4;
    endfunction

    function automatic int exp_an();
        int  k;
        bit  all_zero;
        k = cur_slot();
        all_zero = 1'b1;
        for (int j = k; j < 4; j++)
            if (m_act[j] != 0) all_zero = 1'b0;
        if (lz_blank && k > 0 && all_zero) return 0;
        return 1 << k;
    endfunction

    task automatic model_edge();
        if (rst) begin
            t = 0;
            m_pend = 1'b0;
            for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        end else begin
            if (t % (4 * DIV) == 4 * DIV - 1) begin
                if (m_pend || commit)
                    for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                m_pend = 1'b0;
            end else if (commit) begin
                m_pend = 1'b1;
            end
            if (wr_en) m_sh[wr_addr] = int'(wr_data);
            t++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("an", an, exp_an());
        check("x", {x0, x1, x2, x3}, m_act[cur_slot()]);
        check("commit_pend", commit_pend, m_pend);
    endtask

    task automatic idle(input int n);
        rst = 0; wr_en = 0; commit = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int a, input int d);
        rst = 0; commit = 0; wr_en = 1; wr_addr = 2'(a); wr_data = 4'(d);
        step();
        wr_en = 0;
    endtask

    task automatic pulse_commit();
        rst = 0; wr_en = 0; commit = 1;
        step();
        commit = 0;
    endtask

    task automatic align(input int phase);
        rst = 0; wr_en = 0; commit = 0;
        for (int i = 0; i < 4 * DIV && (t % (4 * DIV)) != phase; i++) step();
    endtask

    initial begin
        rst = 1; wr_en = 0; commit = 0; lz_blank = 0; wr_addr = 0; wr_data = 0;
        t = 0; m_pend = 0;
        for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end

        // Reset state and first slot advance
        step();
        check("rst_an", an, 4'b0001);
        check("rst_x", {x0, x1, x2, x3}, 4'h0);
        check("rst_pend", commit_pend, 1'b0);
        rst = 0;
        for (int i = 0; i < DIV - 1; i++) begin
            step();
            check("slot0_hold", an, 4'b0001);
        end
        step();
        check("slot1_start", an, 4'b0010);
        idle(20);

        // Write 1..4 and commit
        for (int a = 0; a < 4; a++) write(a, a + 1);
        align(2);
        pulse_commit();
        check("pend_set", commit_pend, 1'b1);
        idle(20);
        align(0);
        for (int k = 0; k < 4; k++) begin
            check("frame_x", {x0, x1, x2, x3}, k + 1);
            check("frame_an", an, 1 << k);
            idle(DIV);
        end

        // No tearing: shadow write without commit is invisible
        write(0, 9);
        idle(3 * 4 * DIV);
        align(0);
        check("no_tear", {x0, x1, x2, x3}, 4'h1);

        // Leading-zero blanking with active = 0,0,5,0
        write(0, 0); write(1, 5); write(2, 0); write(3, 0);
        pulse_commit();
        lz_blank = 1;
        idle(2 * 4 * DIV);
        align(0);
        check("lz_s0_an", an, 4'b0001);
        check("lz_s0_x", {x0, x1, x2, x3}, 4'h0);
        idle(DIV);
        check("lz_s1_an", an, 4'b0010);
        check("lz_s1_x", {x0, x1, x2, x3}, 4'h5);
        idle(DIV);
        check("lz_s2_an", an, 4'b0000);
        idle(DIV);
        check("lz_s3_an", an, 4'b0000);
        lz_blank = 0;
        idle(4 * DIV);

        // Commit and write colliding with the frame boundary
        align(4 * DIV - 1);
        commit = 1; wr_en = 1; wr_addr = 2'd1; wr_data = 4'd7;
        step();
        commit = 0; wr_en = 0;
        check("coll_pend", commit_pend, 1'b0);
        align(DIV);
        check("coll_slot1", {x0, x1, x2, x3}, 4'h5);
        pulse_commit();
        idle(2 * 4 * DIV);
        align(DIV);
        check("coll_slot1_new", {x0, x1, x2, x3}, 4'h7);

        // Reset while a commit is pending
        align(2);
        pulse_commit();
        check("pend_before_rst", commit_pend, 1'b1);
        rst = 1;
        step();
        check("rst_mid_pend", commit_pend, 1'b0);
        idle(4 * DIV);
        for (int k = 0; k < 4; k++) begin
            check("rst_mid_x", {x0, x1, x2, x3}, 4'h0);
            idle(DIV);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            commit   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
